// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - CPU bus responder: mirrored RAM, open bus and a timed external port
module bus_responder #(
    parameter int RAM_AW      = 11,
    parameter int EXT_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bus_valid,
    input  logic [15:0] addr,
    input  logic        r_w_n,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        rdy,
    output logic        ext_req,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    output logic        ext_we,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    output logic        timeout_err
);

    localparam int CW = $clog2(EXT_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(EXT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXT_WAIT = 2'd1,
        EXT_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [7:0]      ram [0:(2**RAM_AW)-1];

    logic ram_sel;
    logic ext_sel;
    logic idle_go;
    logic ack_hit;
    logic to_hit;

    assign ram_sel = (addr < 16'h2000);
    assign ext_sel = (addr >= 16'h4020);
    assign idle_go = (state == IDLE) && bus_valid;
    assign ack_hit = (state == EXT_WAIT) && ext_ack;
    // An ack arriving on the final wait cycle wins over the timeout.
    assign to_hit  = (state == EXT_WAIT) && !ext_ack && (cnt == CNT_LAST);

    assign rdy     = (state != EXT_WAIT);
    assign ext_req = (state == EXT_WAIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus_valid && ext_sel) begin
                    state_nxt = EXT_WAIT;
                end
            end
            EXT_WAIT: begin
                if (ack_hit || to_hit) begin
                    state_nxt = EXT_DONE;
                end
            end
            EXT_DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // RAM has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (idle_go && ram_sel && !r_w_n) begin
            ram[addr[RAM_AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            data_out    <= 8'h00;
            data_oe     <= 1'b0;
            ext_addr    <= 16'h0000;
            ext_wdata   <= 8'h00;
            ext_we      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            data_oe <= 1'b0;
            if (idle_go) begin
                if (ext_sel) begin
                    cnt       <= '0;
                    ext_addr  <= addr;
                    ext_wdata <= data_in;
                    ext_we    <= !r_w_n;
                end else if (r_w_n) begin
                    // Open-bus reads keep data_out, so only ram reads reload it.
                    if (ram_sel) begin
                        data_out <= ram[addr[RAM_AW-1:0]];
                    end
                    data_oe <= 1'b1;
                end
            end else if (state == EXT_WAIT) begin
                if (ack_hit || to_hit) begin
                    ext_we <= 1'b0;
                    if (!ext_we) begin
                        data_out <= ack_hit ? ext_rdata : 8'hFF;
                        data_oe  <= 1'b1;
                    end
                    if (to_hit) begin
                        timeout_err <= 1'b1;
                    end
                end else if (cnt != CNT_LAST) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - directed self-checking bench for bus_responder
module tb_bus_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        bus_valid;
    logic [15:0] addr;
    logic        r_w_n;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        rdy;
    logic        ext_req;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_we;
    logic        ext_ack;
    logic [7:0]  ext_rdata;
    logic        timeout_err;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bus_responder #(.RAM_AW(11), .EXT_TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .bus_valid(bus_valid), .addr(addr),
        .r_w_n(r_w_n), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .rdy(rdy), .ext_req(ext_req), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_we(ext_we), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
        .timeout_err(timeout_err)
    );

    // Drive one bus strobe; returns 1 time unit after the edge that captured it.
    task automatic strobe(input logic [15:0] a, input logic rw, input logic [7:0] d);
        @(posedge clk); #1;
        bus_valid = 1'b1; addr = a; r_w_n = rw; data_in = d;
        @(posedge clk); #1;
        bus_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; bus_valid = 1'b0; addr = 16'h0; r_w_n = 1'b1;
        data_in = 8'h0; ext_ack = 1'b0; ext_rdata = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (rdy !== 1'b1) $display("FAIL reset_rdy got %b want 1", rdy); else passed++;
        total++; if (ext_req !== 1'b0) $display("FAIL reset_ext_req got %b want 0", ext_req); else passed++;
        total++; if (data_oe !== 1'b0) $display("FAIL reset_data_oe got %b want 0", data_oe); else passed++;
        total++; if (data_out !== 8'h00) $display("FAIL reset_data_out got %h want 00", data_out); else passed++;
        total++; if (ext_addr !== 16'h0000) $display("FAIL reset_ext_addr got %h want 0000", ext_addr); else passed++;
        total++; if (ext_wdata !== 8'h00) $display("FAIL reset_ext_wdata got %h want 00", ext_wdata); else passed++;
        total++; if (ext_we !== 1'b0) $display("FAIL reset_ext_we got %b want 0", ext_we); else passed++;
        total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err got %b want 0", timeout_err); else passed++;
        reset_n = 1'b1;
    endtask

    task automatic test_ram_mirror();
        strobe(16'h0012, 1'b0, 8'h5A);
        total++; if (data_oe !== 1'b0) $display("FAIL ram_wr_oe got %b want 0", data_oe); else passed++;
        total++; if (rdy !== 1'b1) $display("FAIL ram_wr_rdy got %b want 1", rdy); else passed++;
        strobe(16'h0812, 1'b1, 8'h00);
        total++; if (data_out !== 8'h5A) $display("FAIL ram_mirror_data got %h want 5a", data_out); else passed++;
        total++; if (data_oe !== 1'b1) $display("FAIL ram_mirror_oe got %b want 1", data_oe); else passed++;
        total++; if (rdy !== 1'b1) $display("FAIL ram_mirror_rdy got %b want 1", rdy); else passed++;
        @(posedge clk); #1;
        total++; if (data_oe !== 1'b0) $display("FAIL ram_oe_one_cycle got %b want 0", data_oe); else passed++;
        strobe(16'h1FFF, 1'b0, 8'h77);
        strobe(16'h07FF, 1'b1, 8'h00);
        total++; if (data_out !== 8'h77) $display("FAIL ram_top_mirror got %h want 77", data_out); else passed++;
    endtask

    task automatic test_open_bus();
        strobe(16'h0012, 1'b1, 8'h00);
        total++; if (data_out !== 8'h5A) $display("FAIL ob_ram_read got %h want 5a", data_out); else passed++;
        strobe(16'h2002, 1'b1, 8'h00);
        total++; if (data_out !== 8'h5A) $display("FAIL ob_read got %h want 5a", data_out); else passed++;
        total++; if (data_oe !== 1'b1) $display("FAIL ob_read_oe got %b want 1", data_oe); else passed++;
        strobe(16'h2002, 1'b0, 8'h33);
        total++; if (data_oe !== 1'b0) $display("FAIL ob_write_oe got %b want 0", data_oe); else passed++;
        strobe(16'h2002, 1'b1, 8'h00);
        total++; if (data_out !== 8'h5A) $display("FAIL ob_after_write got %h want 5a", data_out); else passed++;
        strobe(16'h401F, 1'b1, 8'h00);
        total++; if (ext_req !== 1'b0) $display("FAIL ob_top_no_req got %b want 0", ext_req); else passed++;
        total++; if (data_out !== 8'h5A || data_oe !== 1'b1)
            $display("FAIL ob_top_read got %h/%b want 5a/1", data_out, data_oe); else passed++;
    endtask

    task automatic test_ext_read();
        strobe(16'h8000, 1'b1, 8'h00);
        total++; if (ext_req !== 1'b1) $display("FAIL ext_rd_req got %b want 1", ext_req); else passed++;
        total++; if (rdy !== 1'b0) $display("FAIL ext_rd_rdy got %b want 0", rdy); else passed++;
        total++; if (ext_addr !== 16'h8000) $display("FAIL ext_rd_addr got %h want 8000", ext_addr); else passed++;
        total++; if (ext_we !== 1'b0) $display("FAIL ext_rd_we got %b want 0", ext_we); else passed++;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rdy !== 1'b0 || ext_req !== 1'b1)
            $display("FAIL ext_rd_wait got rdy %b req %b want 0/1", rdy, ext_req); else passed++;
        ext_ack = 1'b1; ext_rdata = 8'hC3;
        @(posedge clk); #1;
        ext_ack = 1'b0; ext_rdata = 8'h00;
        total++; if (ext_req !== 1'b0) $display("FAIL ext_rd_req_drop got %b want 0", ext_req); else passed++;
        total++; if (rdy !== 1'b1) $display("FAIL ext_rd_done_rdy got %b want 1", rdy); else passed++;
        total++; if (data_out !== 8'hC3 || data_oe !== 1'b1)
            $display("FAIL ext_rd_data got %h/%b want c3/1", data_out, data_oe); else passed++;
        @(posedge clk); #1;
        total++; if (data_oe !== 1'b0) $display("FAIL ext_rd_oe_end got %b want 0", data_oe); else passed++;
    endtask

    task automatic test_ext_write();
        strobe(16'h4020, 1'b0, 8'h9E);
        total++; if (ext_req !== 1'b1 || ext_addr !== 16'h4020)
            $display("FAIL ext_wr_req got %b/%h want 1/4020", ext_req, ext_addr); else passed++;
        total++; if (ext_we !== 1'b1 || ext_wdata !== 8'h9E)
            $display("FAIL ext_wr_we got %b/%h want 1/9e", ext_we, ext_wdata); else passed++;
        ext_ack = 1'b1;
        @(posedge clk); #1;
        ext_ack = 1'b0;
        total++; if (data_oe !== 1'b0 || data_out !== 8'hC3)
            $display("FAIL ext_wr_done got %h/%b want c3/0", data_out, data_oe); else passed++;
        @(posedge clk); #1;
        total++; if (rdy !== 1'b1 || ext_req !== 1'b0)
            $display("FAIL ext_wr_idle got %b/%b want 1/0", rdy, ext_req); else passed++;
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        strobe(16'hFFFC, 1'b1, 8'h00);
        for (int i = 0; i < 40 && ext_req === 1'b1; i++) begin
            req_cycles++;
            @(posedge clk); #1;
        end
        total++; if (req_cycles != 15) $display("FAIL to_req_cycles got %0d want 15", req_cycles); else passed++;
        total++; if (data_out !== 8'hFF || data_oe !== 1'b1)
            $display("FAIL to_data got %h/%b want ff/1", data_out, data_oe); else passed++;
        total++; if (timeout_err !== 1'b1) $display("FAIL to_err got %b want 1", timeout_err); else passed++;
        repeat (5) @(posedge clk);
        #1;
        total++; if (timeout_err !== 1'b1) $display("FAIL to_err_sticky got %b want 1", timeout_err); else passed++;
    endtask

    task automatic test_ack_on_timeout();
        do_reset();
        total++; if (timeout_err !== 1'b0) $display("FAIL aot_err_cleared got %b want 0", timeout_err); else passed++;
        strobe(16'h9000, 1'b1, 8'h00);
        bus_valid = 1'b1; addr = 16'h0012; r_w_n = 1'b0; data_in = 8'hEE;
        @(posedge clk); #1;
        bus_valid = 1'b0;
        total++; if (ext_addr !== 16'h9000) $display("FAIL aot_no_new_req got %h want 9000", ext_addr); else passed++;
        repeat (13) @(posedge clk);
        #1;
        total++; if (ext_req !== 1'b1) $display("FAIL aot_still_wait got %b want 1", ext_req); else passed++;
        ext_ack = 1'b1; ext_rdata = 8'h3C;
        @(posedge clk); #1;
        ext_ack = 1'b0;
        total++; if (data_out !== 8'h3C || data_oe !== 1'b1)
            $display("FAIL aot_data got %h/%b want 3c/1", data_out, data_oe); else passed++;
        total++; if (timeout_err !== 1'b0) $display("FAIL aot_err got %b want 0", timeout_err); else passed++;
        strobe(16'h0012, 1'b1, 8'h00);
        total++; if (data_out !== 8'h5A) $display("FAIL aot_ram_kept got %h want 5a", data_out); else passed++;
    endtask

    task automatic test_reset_mid_access();
        strobe(16'hA000, 1'b1, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        total++; if (ext_req !== 1'b0 || rdy !== 1'b1)
            $display("FAIL rst_mid got req %b rdy %b want 0/1", ext_req, rdy); else passed++;
        @(posedge clk); #1;
        reset_n = 1'b1;
        ext_ack = 1'b1; ext_rdata = 8'h99;
        @(posedge clk); #1;
        ext_ack = 1'b0;
        total++; if (data_oe !== 1'b0 || ext_req !== 1'b0)
            $display("FAIL rst_late_ack got oe %b req %b want 0/0", data_oe, ext_req); else passed++;
        total++; if (data_out !== 8'h00) $display("FAIL rst_late_data got %h want 00", data_out); else passed++;
    endtask

    initial begin
        test_reset();
        test_ram_mirror();
        test_open_bus();
        test_ext_read();
        test_ext_write();
        test_timeout();
        test_ack_on_timeout();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter RAM_AW, default 11, SHALL set internal RAM address width (2^RAM_AW bytes, 2 KB).
REQ-002 Parameter EXT_TIMEOUT, default 15, SHALL set the maximum number of cycles spent waiting for ext_ack.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 bus_valid  input  1  SHALL be a one-cycle strobe marking a CPU bus cycle with addr/r_w_n/data_in valid.
REQ-006 addr  input  16  SHALL be the CPU address.
REQ-007 r_w_n  input  1  SHALL select the access type: 1 = read, 0 = write.
REQ-008 data_in  input  8  SHALL carry CPU write data.
REQ-009 data_out  output  8  SHALL carry read data to the CPU.
REQ-010 data_oe  output  1  SHALL be high for exactly one cycle when data_out holds valid read data.
REQ-011 rdy  output  1  SHALL be the CPU ready line; low stalls the CPU.
REQ-012 ext_req  output  1  SHALL be the external-port request, level, held until ack or timeout.
REQ-013 ext_addr  output  16  SHALL carry the external-port address, registered.
REQ-014 ext_wdata  output  8  SHALL carry the external-port write data, registered.
REQ-015 ext_we  output  1  SHALL be the external-port write enable, registered, valid while ext_req is high.
REQ-016 ext_ack  input  1  SHALL be the external completion strobe.
REQ-017 ext_rdata  input  8  SHALL carry external read data, valid with ext_ack.
REQ-018 timeout_err  output  1  SHALL be a sticky flag for an external access that timed out.

Function
REQ-019 Decode SHALL map 0x0000-0x1FFF to RAM (index addr[RAM_AW-1:0], mirrored), 0x2000-0x401F to open bus, and 0x4020-0xFFFF to the external port.
REQ-020 A RAM write SHALL update the RAM on the bus_valid edge; data_oe SHALL stay low.
REQ-021 A RAM read SHALL present data on data_out with data_oe high on the cycle after bus_valid, without dropping rdy.
REQ-022 An open-bus read SHALL return the last value driven on data_out, with data_oe high the next cycle.
REQ-023 An open-bus write SHALL be discarded.
REQ-024 The FSM SHALL have three states: IDLE, EXT_WAIT and EXT_DONE.
REQ-025 IDLE -> EXT_WAIT SHALL occur on bus_valid to the external region; the next cycle SHALL show ext_req=1, rdy=0 and registered ext_addr/ext_wdata/ext_we.
REQ-026 In EXT_WAIT, ext_ack SHALL move the FSM to EXT_DONE, deassert ext_req, and capture ext_rdata (reads only).
REQ-027 In EXT_WAIT, EXT_TIMEOUT cycles without ack SHALL move the FSM to EXT_DONE, set timeout_err, deassert ext_req, and make read data 0xFF.
REQ-028 ext_ack and timeout in the same cycle SHALL be resolved as an ack, with timeout_err unchanged.
REQ-029 EXT_DONE SHALL last one cycle: rdy=1, data_oe=1 for reads, then return to IDLE.
REQ-030 bus_valid while the FSM is not IDLE SHALL be ignored, with no RAM write and no new request.
REQ-031 ext_ack while in IDLE or EXT_DONE SHALL be ignored.
REQ-032 The timeout counter SHALL clear on EXT_WAIT entry and SHALL NOT wrap.
REQ-033 timeout_err SHALL clear only on reset.

Reset
REQ-034 Reset assertion SHALL force immediately: FSM=IDLE, rdy=1, ext_req=0, ext_we=0, data_oe=0, data_out=0x00, ext_addr=0x0000, ext_wdata=0x00, timeout_err=0, counter=0.
REQ-035 Reset mid external access SHALL abandon the access; a late ext_ack after release SHALL be ignored.
REQ-036 RAM contents SHALL NOT be reset.

Verification
REQ-037 Write 0x5A to 0x0012, then read 0x0812 (mirror) -> data_out=0x5A with data_oe=1 one cycle after the read strobe; rdy stays 1.
REQ-038 Read 0x0012 (0x5A), then read 0x2002 -> data_out=0x5A (open bus); write 0x33 to 0x2002, read 0x2002 -> still 0x5A.
REQ-039 Read 0x8000, ext_ack with ext_rdata=0xC3 after 4 cycles -> rdy low for the wait, ext_addr=0x8000, ext_we=0, then data_out=0xC3 and data_oe=1 in EXT_DONE.
REQ-040 Read 0xFFFC with no ack -> ext_req drops after 15 cycles, data_out=0xFF, timeout_err=1 and persisting.
REQ-041 Ack on the exact timeout cycle -> ack data returned, timeout_err=0; a second bus_valid during EXT_WAIT -> no RAM change.
REQ-042 reset_n low during EXT_WAIT -> ext_req=0 and rdy=1 immediately; ext_ack after release -> no data_oe.
